// File: rtl/adder_mon_pkg.sv
// Shared types and default widths for the adder error monitor.
package adder_mon_pkg;

    localparam int unsigned WIDTH_DEF = 16;
    localparam int unsigned CNT_W_DEF = 32;
    localparam int unsigned ACC_W_DEF = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/abs_err_stage.sv
// S1/S2 of the monitor pipeline: exact sum and captured result, then
// absolute difference and mismatch flag, each with its own valid bit.
module abs_err_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH:0]   res,
    output logic             s1_valid,
    output logic             s2_valid,
    output logic [WIDTH:0]   abs_err,
    output logic             mismatch
);

    logic [WIDTH:0] s1_exact;
    logic [WIDTH:0] s1_res;

    // S1: full-carry reference sum alongside the adder's reported result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_exact <= '0;
            s1_res   <= '0;
        end else begin
            s1_valid <= valid;
            s1_exact <= {1'b0, a} + {1'b0, b} + (WIDTH + 1)'(cin);
            s1_res   <= res;
        end
    end

    // S2: unsigned distance between reported and exact results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            abs_err  <= '0;
            mismatch <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
            abs_err  <= (s1_res >= s1_exact) ? (s1_res - s1_exact) : (s1_exact - s1_res);
            mismatch <= (s1_res != s1_exact);
        end
    end

endmodule

// File: rtl/adder_error_monitor.sv
// Accumulates error statistics of an approximate adder over a programmed
// run of N samples received over a valid/ready handshake.
module adder_error_monitor
    import adder_mon_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic [WIDTH:0]   in_res,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [ACC_W-1:0] sum_abs_err,
    output logic [WIDTH:0]   max_abs_err
);

    state_t           state;
    logic [CNT_W-1:0] n_q;
    logic             xfer;
    logic             start_acc;
    logic             last_xfer;
    logic [CNT_W:0]   cnt_inc;
    logic [ACC_W:0]   sum_ext;
    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH:0]   s2_abs;
    logic             s2_mismatch;

    assign xfer      = in_valid & in_ready;
    assign start_acc = start & ((state == IDLE) | (state == DONE));
    assign cnt_inc   = {1'b0, sample_count} + (CNT_W + 1)'(1);
    assign last_xfer = xfer & (cnt_inc >= {1'b0, n_q});
    assign sum_ext   = {1'b0, sum_abs_err} + (ACC_W + 1)'(s2_abs);

    abs_err_stage #(
        .WIDTH (WIDTH)
    ) u_abs_err_stage (
        .clk      (clk),
        .rst      (rst),
        .valid    (xfer),
        .a        (in_a),
        .b        (in_b),
        .cin      (in_cin),
        .res      (in_res),
        .s1_valid (s1_valid),
        .s2_valid (s2_valid),
        .abs_err  (s2_abs),
        .mismatch (s2_mismatch)
    );

    // Run control; DRAIN waits only on S1 since S2 retires on the same edge as the exit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            n_q      <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state    <= RUN;
                        n_q      <= num_samples;
                        in_ready <= (num_samples != '0);
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end
                RUN: begin
                    if (last_xfer || (n_q == '0)) begin
                        state    <= DRAIN;
                        in_ready <= 1'b0;
                    end
                end
                DRAIN: begin
                    if (!s1_valid) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // S3: saturating statistics; sample_count tracks the accept edge directly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_count <= '0;
            err_count    <= '0;
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
        end else if (start_acc) begin
            sample_count <= '0;
            err_count    <= '0;
            sum_abs_err  <= '0;
            max_abs_err  <= '0;
        end else begin
            if (xfer && !(&sample_count)) begin
                sample_count <= cnt_inc[CNT_W-1:0];
            end
            if (s2_valid) begin
                if (s2_mismatch && !(&err_count)) begin
                    err_count <= err_count + CNT_W'(1);
                end
                sum_abs_err <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
                if (s2_abs >= max_abs_err) begin
                    max_abs_err <= s2_abs;
                end
            end
        end
    end

endmodule

// File: tb/tb_adder_error_monitor.sv
// Self-checking bench: directed scenarios plus randomized runs against a
// sample-level statistics model.
module tb_adder_error_monitor;

    localparam int unsigned W   = 16;
    localparam int unsigned CW  = 32;
    localparam int unsigned AW  = 48;
    localparam int unsigned SAW = 18;

    logic          clk;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_samples;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic          in_cin;
    logic [W:0]    in_res;
    logic          busy;
    logic          done;
    logic [CW-1:0] sample_count;
    logic [CW-1:0] err_count;
    logic [AW-1:0] sum_abs_err;
    logic [W:0]    max_abs_err;

    logic           s_start;
    logic [CW-1:0]  s_num;
    logic           s_valid;
    logic           s_ready;
    logic [W-1:0]   s_a;
    logic [W-1:0]   s_b;
    logic           s_cin;
    logic [W:0]     s_res;
    logic           s_busy;
    logic           s_done;
    logic [CW-1:0]  s_cnt;
    logic [CW-1:0]  s_err;
    logic [SAW-1:0] s_sum;
    logic [W:0]     s_max;

    int checks = 0;
    int errors = 0;

    // Reference model state: statistics of the samples the monitor should accept
    bit          m_started;
    int unsigned m_n;
    int unsigned m_cnt;
    longint unsigned m_err;
    longint unsigned m_sum;
    longint unsigned m_max;

    adder_error_monitor dut (
        .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_cin(in_cin), .in_res(in_res), .busy(busy), .done(done),
        .sample_count(sample_count), .err_count(err_count),
        .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err)
    );

    adder_error_monitor #(.WIDTH(W), .CNT_W(CW), .ACC_W(SAW)) dut_sat (
        .clk(clk), .rst(rst), .start(s_start), .num_samples(s_num),
        .in_valid(s_valid), .in_ready(s_ready), .in_a(s_a), .in_b(s_b),
        .in_cin(s_cin), .in_res(s_res), .busy(s_busy), .done(s_done),
        .sample_count(s_cnt), .err_count(s_err),
        .sum_abs_err(s_sum), .max_abs_err(s_max)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [W:0] exact_of(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin);
        return (W + 1)'(a) + (W + 1)'(b) + (W + 1)'(cin);
    endfunction

    task automatic model_clear();
        m_cnt = 0;
        m_err = 0;
        m_sum = 0;
        m_max = 0;
    endtask

    task automatic model_accept(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic cin, input logic [W:0] res);
        longint unsigned ex;
        longint unsigned r;
        longint unsigned d;
        longint unsigned sat;
        ex  = longint'(a) + longint'(b) + longint'(cin);
        r   = longint'(res);
        d   = (r > ex) ? r - ex : ex - r;
        sat = (64'd1 << AW) - 1;
        if (d != 0) m_err++;
        m_sum = (m_sum + d > sat) ? sat : m_sum + d;
        if (d > m_max) m_max = d;
        m_cnt++;
    endtask

    // One clock: drive at negedge, check handshake, let the model take the sample
    task automatic cycle(input bit st, input bit v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin, input logic [W:0] res);
        bit exp_ready;
        @(negedge clk);
        start    = st;
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_res   = res;
        exp_ready = m_started && (m_cnt < m_n);
        chk("in_ready", 64'(in_ready), 64'(exp_ready));
        if (v && exp_ready) model_accept(a, b, cin, res);
        @(posedge clk);
        #1;
        start    = 1'b0;
        in_valid = 1'b0;
    endtask

    task automatic start_run(input int unsigned n, input bit ignored);
        num_samples = CW'(n);
        cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
        if (!ignored) begin
            m_started = 1'b1;
            m_n       = n;
            model_clear();
        end
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
            k++;
        end
        chk("done", 64'(done), 64'd1);
        chk("busy_at_done", 64'(busy), 64'd0);
        chk("sample_count", 64'(sample_count), 64'(m_cnt));
        chk("err_count", 64'(err_count), m_err);
        chk("sum_abs_err", 64'(sum_abs_err), m_sum);
        chk("max_abs_err", 64'(max_abs_err), m_max);
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_sample_count", 64'(sample_count), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_sum", 64'(sum_abs_err), 64'd0);
        chk("rst_max", 64'(max_abs_err), 64'd0);
    endtask

    task automatic rand_sample(input int err_pct);
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W:0]   r;
        a = W'($urandom);
        b = W'($urandom);
        c = 1'($urandom);
        r = exact_of(a, b, c);
        if (int'($urandom_range(0, 99)) < err_pct)
            r = r ^ (W + 1)'($urandom_range(1, 32'h1FFFF));
        cycle(1'b0, 1'($urandom), a, b, c, r);
    endtask

    initial begin
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           c;
        longint unsigned sat_tot;
        longint unsigned sat_exp;

        rst = 1'b1;
        start = 1'b0; num_samples = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_res = '0;
        s_start = 1'b0; s_num = '0; s_valid = 1'b0;
        s_a = '0; s_b = '0; s_cin = 1'b0; s_res = '0;
        m_started = 1'b0; m_n = 0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk_reset();
        @(negedge clk);
        rst = 1'b0;

        // Exact results only
        start_run(4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            cycle(1'b0, 1'b1, a, b, c, exact_of(a, b, c));
        end
        wait_done(3);
        chk("exact_count", 64'(sample_count), 64'd4);
        chk("exact_err", 64'(err_count), 64'd0);

        // Directed error samples including the carry-out case
        start_run(3, 1'b0);
        cycle(1'b0, 1'b1, 16'd1, 16'd1, 1'b0, 17'd3);
        cycle(1'b0, 1'b1, 16'hFFFF, 16'd1, 1'b0, 17'h00000);
        cycle(1'b0, 1'b1, 16'd5, 16'd5, 1'b1, 17'd11);
        wait_done(3);
        chk("err_run_err", 64'(err_count), 64'd2);
        chk("err_run_sum", 64'(sum_abs_err), 64'h10001);
        chk("err_run_max", 64'(max_abs_err), 64'h10000);

        // Handshake with toggling valid, then a surplus valid sample
        start_run(5, 1'b0);
        for (int i = 0; i < 10; i++) begin
            a = W'($urandom); b = W'($urandom);
            cycle(1'b0, (i % 2) == 0, a, b, 1'b0, exact_of(a, b, 1'b0) + 17'd2);
        end
        cycle(1'b0, 1'b1, 16'd7, 16'd7, 1'b0, 17'd99);
        chk("hs_done_latency", 64'(done), 64'd1);
        wait_done(0);
        chk("hs_count", 64'(sample_count), 64'd5);

        // Empty run
        start_run(0, 1'b0);
        wait_done(3);

        // Start pulsed mid-run is ignored
        start_run(8, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'd3, 16'd4, 1'b1, 17'd8);
        start_run(2, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'd9, 16'd9, 1'b0, 17'd18);
        wait_done(3);
        chk("ign_start_count", 64'(sample_count), 64'd8);

        // Reset in the middle of a run, then a clean restart
        start_run(10, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 16'd1, 16'd2, 1'b0, 17'd4);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset();
        m_started = 1'b0; m_n = 0;
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        start_run(2, 1'b0);
        cycle(1'b0, 1'b1, 16'd100, 16'd200, 1'b0, 17'd290);
        cycle(1'b0, 1'b1, 16'd1, 16'd1, 1'b1, 17'd3);
        wait_done(3);
        chk("restart_sum", 64'(sum_abs_err), 64'd10);

        // Randomized runs
        for (int r = 0; r < 6; r++) begin
            int k;
            start_run(int'($urandom_range(1, 12)), 1'b0);
            k = 0;
            while (m_cnt < m_n && k < 200) begin
                rand_sample(40);
                k++;
            end
            wait_done(4);
        end

        // Saturating accumulator on a narrow instance
        @(negedge clk);
        s_start = 1'b1; s_num = CW'(3);
        @(negedge clk);
        s_start = 1'b0; s_valid = 1'b1; s_res = 17'h1FFFF;
        for (int i = 0; i < 3; i++) begin
            chk("sat_ready", 64'(s_ready), 64'd1);
            @(negedge clk);
        end
        s_valid = 1'b0;
        chk("sat_ready_after", 64'(s_ready), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        sat_tot = 3 * 64'h1FFFF;
        sat_exp = (sat_tot > 64'h3FFFF) ? 64'h3FFFF : sat_tot;
        chk("sat_done", 64'(s_done), 64'd1);
        chk("sat_sum", 64'(s_sum), sat_exp);
        chk("sat_err", 64'(s_err), 64'd3);
        chk("sat_max", 64'(s_max), 64'h1FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
